// File: rtl/tt_out_capture.sv
// tt_out_capture: timestamped change capture of the TinyTapeout output pin bundle.
// Latency: an entry captured at edge k shows on rd_valid/rd_data/rd_ts right after edge k.
// Backpressure: rd_ready low lets the FIFO fill; a capture arriving when full with no pop is dropped and counted.
//
// Ports:
//   clk, rst           clock, asynchronous active-high reset
//   en                 arm; capture and timestamp run only while high
//   clr                synchronous flush of FIFO, overflow, drop_cnt and timestamp
//   ch_in              NCH channels of WIDTH bits, channel 0 in the LSBs
//   force_cap          capture this cycle even with no change
//   rd_valid/rd_ready  first-word-fall-through read handshake
//   rd_data, rd_ts     head snapshot and its timestamp (held when empty)
//   count              entries held
//   overflow, drop_cnt sticky drop flag, saturating drop counter
//
// Optional build macro TT_CAP_DELTA_TS_EN: rd_ts carries the saturating cycle
// delta since the previous capture instead of the absolute wrapping time.
module tt_out_capture #(
  parameter int WIDTH = 8,
  parameter int NCH   = 3,
  parameter int DEPTH = 16,
  parameter int TS_W  = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       en,
  input  logic                       clr,
  input  logic [NCH*WIDTH-1:0]       ch_in,
  input  logic                       force_cap,
  output logic                       rd_valid,
  input  logic                       rd_ready,
  output logic [NCH*WIDTH-1:0]       rd_data,
  output logic [TS_W-1:0]            rd_ts,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       overflow,
  output logic [7:0]                 drop_cnt
);

  localparam int DW = NCH * WIDTH;
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] ONE_C   = CW'(1);

  generate
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
      $error("tt_out_capture: DEPTH must be a power of two and at least 2");
    end
  endgenerate

  typedef struct packed {
    logic [DW-1:0]   dat;
    logic [TS_W-1:0] ts;
  } entry_t;

  entry_t        mem [DEPTH];
  entry_t        wr_entry;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] rd_ptr_nxt;
  logic [DW-1:0] prev_q;
  logic          en_q;
  logic [TS_W-1:0] ts;
  logic          cap;
  logic          pop;
  logic          push;
  logic          drop;

  // First armed cycle (en_q still low) always yields a baseline entry.
  assign cap        = en & (~en_q | (ch_in != prev_q) | force_cap);
  assign rd_valid   = (count != '0);
  assign pop        = rd_valid & rd_ready;
  // A pop in the same cycle frees the slot, so full + read + capture is not a drop.
  assign push       = cap & ((count != DEPTH_C) | pop);
  assign drop       = cap & ~push;
  assign rd_ptr_nxt = rd_ptr + AW'(1);
  assign wr_entry   = '{dat: ch_in, ts: ts};

`ifdef TT_CAP_DELTA_TS_EN
  // Cycles since the last capture, accepted or dropped; sticks at all-ones.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ts <= '0;
    end else if (clr || !en) begin
      ts <= '0;
    end else if (cap) begin
      ts <= TS_W'(1);
    end else if (ts != '1) begin
      ts <= ts + TS_W'(1);
    end
  end
`else
  // Absolute armed time, wrapping; held at zero while disarmed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ts <= '0;
    end else if (clr || !en) begin
      ts <= '0;
    end else begin
      ts <= ts + TS_W'(1);
    end
  end
`endif

  // Storage array carries no reset; only slots between the pointers are ever observed.
  always_ff @(posedge clk) begin
    if (push && !clr) begin
      mem[wr_ptr] <= wr_entry;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_q   <= '0;
      en_q     <= 1'b0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
      drop_cnt <= '0;
      rd_data  <= '0;
      rd_ts    <= '0;
    end else begin
      prev_q <= ch_in;
      if (clr) begin
        // Clearing en_q forces a fresh baseline if en stays high.
        en_q     <= 1'b0;
        wr_ptr   <= '0;
        rd_ptr   <= '0;
        count    <= '0;
        overflow <= 1'b0;
        drop_cnt <= '0;
      end else begin
        en_q <= en;
        if (push) wr_ptr <= wr_ptr + AW'(1);
        if (pop)  rd_ptr <= rd_ptr_nxt;
        if (push && !pop) begin
          count <= count + ONE_C;
        end else if (pop && !push) begin
          count <= count - ONE_C;
        end
        if (drop) begin
          overflow <= 1'b1;
          if (drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
        end
        // Registered head: load the incoming entry when it becomes the head,
        // otherwise step to the next stored entry on a pop; hold when draining empty.
        if (push && (count == '0 || (pop && count == ONE_C))) begin
          {rd_data, rd_ts} <= wr_entry;
        end else if (pop && count > ONE_C) begin
          {rd_data, rd_ts} <= mem[rd_ptr_nxt];
        end
      end
    end
  end

endmodule

// File: tb/tb_tt_out_capture.sv
module tb_tt_out_capture;

  localparam int WIDTH = 8;
  localparam int NCH   = 3;
  localparam int DEPTH = 16;
  localparam int TS_W  = 4;
  localparam int DW    = NCH * WIDTH;
  localparam int CW    = $clog2(DEPTH + 1);

  logic            clk = 1'b0;
  logic            rst;
  logic            en;
  logic            clr;
  logic [DW-1:0]   ch_in;
  logic            force_cap;
  logic            rd_valid;
  logic            rd_ready;
  logic [DW-1:0]   rd_data;
  logic [TS_W-1:0] rd_ts;
  logic [CW-1:0]   count;
  logic            overflow;
  logic [7:0]      drop_cnt;

  int checks   = 0;
  int failures = 0;

  tt_out_capture #(
    .WIDTH(WIDTH), .NCH(NCH), .DEPTH(DEPTH), .TS_W(TS_W)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .clr(clr), .ch_in(ch_in),
    .force_cap(force_cap), .rd_valid(rd_valid), .rd_ready(rd_ready),
    .rd_data(rd_data), .rd_ts(rd_ts), .count(count),
    .overflow(overflow), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          en;
    logic          clr;
    logic          fc;
    logic          rdy;
    logic [DW-1:0] ch;
    logic          vld;
    int            cnt;
    logic [DW-1:0] dat;
    logic [TS_W-1:0] ts_abs;
    logic [TS_W-1:0] ts_dlt;
    logic          ovf;
    int            drp;
  } vec_t;

  vec_t tbl [14];

  function automatic vec_t mkv(input logic e, input logic c, input logic f, input logic r,
                               input logic [DW-1:0] ch, input logic vld, input int cnt,
                               input logic [DW-1:0] dat, input logic [TS_W-1:0] ta,
                               input logic [TS_W-1:0] td, input logic ovf, input int drp);
    vec_t v;
    v.en = e; v.clr = c; v.fc = f; v.rdy = r; v.ch = ch;
    v.vld = vld; v.cnt = cnt; v.dat = dat; v.ts_abs = ta; v.ts_dlt = td;
    v.ovf = ovf; v.drp = drp;
    return v;
  endfunction

  // Pick the timestamp expectation for the build under test.
  function automatic logic [TS_W-1:0] ets(input logic [TS_W-1:0] abs_v, input logic [TS_W-1:0] dlt_v);
`ifdef TT_CAP_DELTA_TS_EN
    return dlt_v;
`else
    return abs_v;
`endif
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic vld, input int cnt,
                         input logic [DW-1:0] dat, input logic [TS_W-1:0] t);
    chk({tag, ".vld"}, 32'(rd_valid), 32'(vld));
    chk({tag, ".cnt"}, 32'(count), 32'(cnt));
    chk({tag, ".dat"}, 32'(rd_data), 32'(dat));
    chk({tag, ".ts"},  32'(rd_ts), 32'(t));
  endtask

  task automatic chk_flags(input string tag, input logic ovf, input int drp);
    chk({tag, ".ovf"},  32'(overflow), 32'(ovf));
    chk({tag, ".drop"}, 32'(drop_cnt), 32'(drp));
  endtask

  task automatic drive(input logic e, input logic c, input logic f, input logic r,
                       input logic [DW-1:0] ch);
    en = e; clr = c; force_cap = f; rd_ready = r; ch_in = ch;
  endtask

  // One active edge, then sample 1 time unit later.
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [DW-1:0] ch;
    logic [DW-1:0] wdat [4];
    logic [TS_W-1:0] wabs [4];
    logic [TS_W-1:0] wdlt [4];

    // ---------------- reset and arm ----------------
    rst = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 1'b0, '0);
    tick; tick;
    chk_out("reset", 1'b0, 0, '0, '0);
    chk_flags("reset", 1'b0, 0);
    rst = 1'b0;

    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 1'b0, 1'b0, 1'b0, DW'(i + 1));
      tick;
    end
    chk("prefill.cnt", 32'(count), 32'd5);

    // Asynchronous reset mid-cycle, away from any clock edge.
    #3 rst = 1'b1;
    #1;
    chk_out("async_rst", 1'b0, 0, '0, '0);
    #2 rst = 1'b0;
    drive(1'b1, 1'b0, 1'b0, 1'b0, 24'h00A53C);
    #1;
    chk("arm_pre_edge.vld", 32'(rd_valid), 32'd0);
    tick;
    chk_out("arm", 1'b1, 1, 24'h00A53C, '0);

    // clr with en low: empty, head value held.
    drive(1'b0, 1'b1, 1'b0, 1'b0, 24'h111111);
    tick;
    chk_out("clr_hold", 1'b0, 0, 24'h00A53C, '0);

    // ---------------- change detect (table) ----------------
    tbl[0]  = mkv(1, 0, 0, 0, 24'h111111, 1, 1, 24'h111111, 4'd0, 4'd0, 0, 0);
    tbl[1]  = mkv(1, 0, 0, 0, 24'h111111, 1, 1, 24'h111111, 4'd0, 4'd0, 0, 0);
    tbl[2]  = mkv(1, 0, 0, 0, 24'h111111, 1, 1, 24'h111111, 4'd0, 4'd0, 0, 0);
    tbl[3]  = mkv(1, 0, 0, 0, 24'h222222, 1, 2, 24'h111111, 4'd0, 4'd0, 0, 0);
    tbl[4]  = mkv(1, 0, 0, 0, 24'h222222, 1, 2, 24'h111111, 4'd0, 4'd0, 0, 0);
    tbl[5]  = mkv(1, 0, 0, 0, 24'h222222, 1, 2, 24'h111111, 4'd0, 4'd0, 0, 0);
    tbl[6]  = mkv(1, 0, 0, 0, 24'h222222, 1, 2, 24'h111111, 4'd0, 4'd0, 0, 0);
    tbl[7]  = mkv(1, 0, 0, 0, 24'h333333, 1, 3, 24'h111111, 4'd0, 4'd0, 0, 0);
    tbl[8]  = mkv(1, 0, 0, 0, 24'h333333, 1, 3, 24'h111111, 4'd0, 4'd0, 0, 0);
    tbl[9]  = mkv(1, 0, 1, 0, 24'h333333, 1, 4, 24'h111111, 4'd0, 4'd0, 0, 0);
    tbl[10] = mkv(0, 0, 0, 1, 24'h333333, 1, 3, 24'h222222, 4'd3, 4'd3, 0, 0);
    tbl[11] = mkv(0, 0, 0, 1, 24'h333333, 1, 2, 24'h333333, 4'd7, 4'd4, 0, 0);
    tbl[12] = mkv(0, 0, 0, 1, 24'h333333, 1, 1, 24'h333333, 4'd9, 4'd2, 0, 0);
    tbl[13] = mkv(0, 0, 0, 1, 24'h333333, 0, 0, 24'h333333, 4'd9, 4'd2, 0, 0);

    for (int i = 0; i < 14; i++) begin
      drive(tbl[i].en, tbl[i].clr, tbl[i].fc, tbl[i].rdy, tbl[i].ch);
      tick;
      chk_out($sformatf("cd[%0d]", i), tbl[i].vld, tbl[i].cnt, tbl[i].dat,
              ets(tbl[i].ts_abs, tbl[i].ts_dlt));
      chk_flags($sformatf("cd[%0d]", i), tbl[i].ovf, tbl[i].drp);
    end

    // ---------------- full / overflow ----------------
    for (int i = 0; i < 20; i++) begin
      drive(1'b1, 1'b0, 1'b0, 1'b0, DW'(i + 1));
      tick;
      if (i == 15) begin
        chk("full16.cnt", 32'(count), 32'd16);
        chk_flags("full16", 1'b0, 0);
      end
      if (i == 16) chk_flags("first_drop", 1'b1, 1);
    end
    chk_out("full20", 1'b1, 16, 24'h000001, 4'd0);
    chk_flags("full20", 1'b1, 4);

    // Full + read + capture in the same cycle: no drop, count stays.
    drive(1'b1, 1'b0, 1'b0, 1'b1, 24'hABCDEF);
    tick;
    chk_out("full_rw", 1'b1, 16, 24'h000002, ets(4'd1, 4'd1));
    chk_flags("full_rw", 1'b1, 4);

    for (int k = 1; k <= 16; k++) begin
      chk_out($sformatf("drain[%0d]", k), 1'b1, 17 - k,
              (k <= 15) ? DW'(k + 1) : 24'hABCDEF,
              ets((k <= 15) ? TS_W'(k) : 4'd4, 4'd1));
      drive(1'b0, 1'b0, 1'b0, 1'b1, 24'hABCDEF);
      tick;
    end
    chk_out("drained", 1'b0, 0, 24'hABCDEF, ets(4'd4, 4'd1));

    // ---------------- timestamp wrap / delta saturation ----------------
    drive(1'b0, 1'b1, 1'b0, 1'b0, 24'h000010);
    tick;
    chk("clr_ovf.cnt", 32'(count), 32'd0);
    chk_flags("clr_ovf", 1'b0, 0);

    for (int c = 0; c <= 40; c++) begin
      ch = (c < 15) ? 24'h000010 : (c < 17) ? 24'h000020 : (c < 40) ? 24'h000030 : 24'h000040;
      drive(1'b1, 1'b0, 1'b0, 1'b0, ch);
      tick;
    end
    chk("wrap.cnt", 32'(count), 32'd4);

    wdat[0] = 24'h000010; wabs[0] = 4'd0;  wdlt[0] = 4'd0;
    wdat[1] = 24'h000020; wabs[1] = 4'd15; wdlt[1] = 4'd15;
    wdat[2] = 24'h000030; wabs[2] = 4'd1;  wdlt[2] = 4'd2;
    wdat[3] = 24'h000040; wabs[3] = 4'd8;  wdlt[3] = 4'd15;
    for (int k = 0; k < 4; k++) begin
      chk_out($sformatf("wrap[%0d]", k), 1'b1, 4 - k, wdat[k], ets(wabs[k], wdlt[k]));
      drive(1'b0, 1'b0, 1'b0, 1'b1, 24'h000040);
      tick;
    end
    chk("wrap_done.vld", 32'(rd_valid), 32'd0);

    // ---------------- clr beats capture and pop ----------------
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b0, 1'b0, 1'b0, DW'(i + 1));
      tick;
    end
    chk("pre_clr.cnt", 32'(count), 32'd3);
    drive(1'b1, 1'b1, 1'b1, 1'b1, 24'h000003);
    tick;
    chk("clr_cap.cnt", 32'(count), 32'd0);
    chk("clr_cap.vld", 32'(rd_valid), 32'd0);
    chk_flags("clr_cap", 1'b0, 0);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 24'h000003);
    tick;
    chk_out("rebase", 1'b1, 1, 24'h000003, 4'd0);
    tick;
    chk("rebase_steady.cnt", 32'(count), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/tt_out_capture.md
Name: tt_out_capture

Overview:
- Parametrised, synthesizable capture block for the TinyTapeout pin bundle (uo_out / uio_out / uio_oe).
- Records a timestamped entry every time any monitored channel changes value.
- Entries go into a FIFO that the bench, or a future on-chip readout, drains through a valid/ready port.
- Generalises the fixed one-instance pin wiring: channel count, channel width, buffer depth and timestamp width are all parameters.

Parameters:
- WIDTH, 8, bits per channel
- NCH, 3, number of monitored channels (channel 0 in LSBs)
- DEPTH, 16, FIFO entries; power of two, >= 2
- TS_W, 16, timestamp width in bits

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- en  in  1  arm; capture and timestamp run only while high
- clr  in  1  synchronous flush: empties FIFO, clears overflow, drop_cnt and timestamp
- ch_in  in  NCH*WIDTH  monitored channels, concatenated
- force_cap  in  1  capture this cycle even if nothing changed
- rd_valid  out  1  FIFO head valid
- rd_ready  in  1  consumer accepts head
- rd_data  out  NCH*WIDTH  head channel snapshot
- rd_ts  out  TS_W  head timestamp
- count  out  $clog2(DEPTH+1)  entries held
- overflow  out  1  sticky; set when a capture is dropped
- drop_cnt  out  8  dropped captures, saturates at 255

Behaviour:
- Reset (async, immediate, including mid-operation) values:
  - rd_valid=0, rd_data=0, rd_ts=0, count=0, overflow=0, drop_cnt=0
  - internal ts=0, en_q=0, prev_q=0
- Registered state:
  - prev_q <= ch_in every cycle, regardless of en.
  - en_q <= en every cycle.
- Capture condition, evaluated per cycle: en & (~en_q | (ch_in != prev_q) | force_cap).
  - The first armed cycle always captures a baseline entry.
- Timestamp counter ts:
  - Held at 0 while en=0.
  - While en=1: increments by 1 per cycle, wraps modulo 2^TS_W.
  - The first armed cycle therefore carries ts=0.
- Entry written = {ch_in, ts}, both sampled in the capture cycle.
- Write latency: an entry captured at edge k gives rd_valid=1 after edge k.
  - FIFO is first-word-fall-through: rd_data/rd_ts show the head while rd_valid=1.
  - rd_data/rd_ts hold their last value when the FIFO is empty.
- Pop: occurs on an edge where rd_valid & rd_ready; rd_ready is ignored when empty.
- Write acceptance:
  - Accepted if count<DEPTH, or if a pop happens in the same cycle (full + read + capture: count stays DEPTH, no drop).
  - Otherwise the capture is dropped: overflow <= 1, drop_cnt increments saturating at 255. FIFO contents are unchanged.
- Simultaneous push and pop when not full: count unchanged, order preserved.
- Pointers are log2(DEPTH) bits and wrap at DEPTH; full/empty is derived from count.
- en low:
  - No captures.
  - FIFO remains readable and drains normally.
  - Re-arming produces a new baseline entry with ts=0.
- clr has priority over capture and pop in the same cycle:
  - Sets count=0, overflow=0, drop_cnt=0, ts=0.
  - Sets en_q=0, so if en stays high the next cycle re-baselines.
- Out-of-range use: DEPTH not a power of two is unsupported; elaboration must fail.

Optional Feature:
- Macro: TT_CAP_DELTA_TS_EN.
- When defined, rd_ts is the cycle delta since the previous accepted-or-dropped capture instead of absolute time:
  - Delta counter is 0 on the first armed cycle.
  - It loads 1 on the edge after each capture and otherwise increments, saturating at 2^TS_W-1 (no wrap).
- When undefined, absolute wrapping timestamp as described in Behaviour; no delta logic is synthesized.

Test Plan:
- Reset/arm: assert rst mid-stream with 5 entries queued -> rd_valid=0, count=0 at once. Release, en=1, ch_in=0x00A5_3C -> one entry {0x00A53C, ts=0}, rd_valid=1 one edge later.
- Change detect: en=1, ch_in changes at armed cycles 3 and 7, constant otherwise -> entries at ts=0, 3, 7 (delta build: 0, 3, 4); force_cap at cycle 9 with no change -> ts=9 (delta 2).
- Full/overflow: DEPTH=16, rd_ready=0, 20 changes -> count=16, overflow=1, drop_cnt=4. Then read all -> first 16 captures in order.
- Full with simultaneous read: FIFO full, rd_ready=1, change in same cycle -> count stays 16, no drop, new entry is last out.
- Wrap: TS_W=4, changes at cycles 15 and 17 -> rd_ts 15 then 1. Delta build with 20-cycle gap -> rd_ts saturates at 15.
- clr vs capture: clr and force_cap in the same cycle with 3 entries queued -> count=0, overflow=0. The next cycle produces a baseline entry with ts=0.
